// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  // First byte of every program frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States of the framing FSM.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  // Clocks per serial bit for a given board clock and baud rate.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 byte receiver: input synchronizer, mid-bit timer and LSB-first shifter.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Bit timer: start-bit recheck at half a bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (r_rx_prev && !r_rx_sync) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            // A line that is high again at mid start bit was only a glitch.
            r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_valid <= r_rx_sync;
            r_ferr  <= !r_rx_sync;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = r_shift;
  assign byte_valid_o = r_valid;
  assign frame_err_o  = r_ferr;

endmodule

// File: rtl/uart_imem_loader.sv
// Program loader: parses the serial frame and writes 32-bit words into instruction memory.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 7,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_i,
  input  logic              load_en_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic       w_load_rise;
  logic       w_len_bad;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .rx_i        (rx_i),
    .byte_o      (w_byte),
    .byte_valid_o(w_byte_valid),
    .frame_err_o (w_frame_err)
  );

  state_t            r_state;
  logic              r_load_en_prev;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_csum;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word_cnt;
  logic              r_hold;
  logic              r_done;
  logic              r_err;

  assign w_load_rise = load_en_i && !r_load_en_prev;
  assign w_len_bad   = (w_byte == 8'd0) || (32'(w_byte) > 32'(MAX_WORDS));

  // Framing FSM with word assembly and write strobe; all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= IDLE;
      r_load_en_prev <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_word         <= '0;
      r_byte_idx     <= '0;
      r_csum         <= '0;
      r_len          <= '0;
      r_word_cnt     <= '0;
      r_hold         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_load_en_prev <= load_en_i;
      r_we           <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_rise) begin
            r_state    <= SYNC;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
          end
        end
        SYNC, LEN, DATA, CSUM: begin
          // Abort wins over everything, including a write due this cycle.
          if (!load_en_i) begin
            r_state <= IDLE;
            r_hold  <= 1'b0;
          end else if (w_frame_err && (r_state != SYNC)) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else if (w_byte_valid) begin
            case (r_state)
              SYNC: begin
                if (w_byte == SYNC_BYTE) r_state <= LEN;
              end
              LEN: begin
                if (w_len_bad) begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
                end else begin
                  r_len   <= LEN_W'(w_byte);
                  r_state <= DATA;
                end
              end
              DATA: begin
                r_csum     <= r_csum ^ w_byte;
                r_word     <= {w_byte, r_word[31:8]};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                  r_we       <= 1'b1;
                  r_addr     <= r_word_cnt[ADDR_W-1:0];
                  r_wdata    <= {w_byte, r_word[31:8]};
                  r_word_cnt <= r_word_cnt + LEN_W'(1);
                  if ((r_word_cnt + LEN_W'(1)) == r_len) r_state <= CSUM;
                end
              end
              CSUM: begin
                if (w_byte == r_csum) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        DONE, ERR: begin
          if (!load_en_i) begin
            r_state <= IDLE;
            r_hold  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign cpu_hold_o   = r_hold;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign word_cnt_o   = r_word_cnt;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for the UART program loader (16 clocks per bit).
module tb_uart_imem_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 7;

  logic              clk;
  logic              rstn;
  logic              rx_i;
  logic              load_en_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:127];
  int          wr_count = 0;
  int          bv_count = 0;
  logic        prev_bv = 1'b0;
  logic        prev_we = 1'b0;

  uart_imem_loader #(
    .CLK_FREQ    (100000000),
    .BAUD        (115200),
    .ADDR_W      (ADDR_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_i        (rx_i),
    .load_en_i   (load_en_i),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .word_cnt_o  (word_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = stop;
    tick(CPB);
    rx_i = 1'b1;
    $display("byte sent %02h stop=%0d", b, stop);
  endtask

  task automatic start_load();
    load_en_i = 1'b0;
    tick(2);
    wr_count  = 0;
    load_en_i = 1'b1;
    tick(2);
  endtask

  task automatic end_load();
    load_en_i = 1'b0;
    tick(2);
  endtask

  // Write monitor: logs each write and checks strobe width and timing.
  always @(negedge clk) begin
    if (rstn) begin
      if (dut.w_byte_valid) bv_count++;
      if (imem_we_o) begin
        chk("we_after_bv", {31'd0, prev_bv}, 32'd1);
        chk("we_width", {31'd0, prev_we}, 32'd0);
        chk("cnt_with_we", 32'(word_cnt_o), 32'(imem_addr_o) + 32'd1);
        mem[imem_addr_o] = imem_wdata_o;
        wr_count++;
        $display("write addr=%0d data=%08h", imem_addr_o, imem_wdata_o);
      end
      prev_bv = dut.w_byte_valid;
      prev_we = imem_we_o;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b0, b1, b2, b3, cs;
    int         bv_before;

    rstn = 1'b0; rx_i = 1'b1; load_en_i = 1'b0;
    tick(3);
    chk("rst_we", {31'd0, imem_we_o}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_cnt", 32'(word_cnt_o), 32'd0);
    rstn = 1'b1;
    tick(3);

    // Basic two-word load.
    start_load();
    chk("basic_hold_start", {31'd0, cpu_hold_o}, 32'd1);
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'hB3, 1); send_byte(8'h00, 1); send_byte(8'h50, 1); send_byte(8'h00, 1);
    send_byte(8'hF0, 1);
    tick(5);
    chk("basic_done", {31'd0, done_o}, 32'd1);
    chk("basic_err", {31'd0, err_o}, 32'd0);
    chk("basic_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("basic_cnt", 32'(word_cnt_o), 32'd2);
    chk("basic_writes", 32'(wr_count), 32'd2);
    chk("basic_w0", mem[0], 32'h0000_0013);
    chk("basic_w1", mem[1], 32'h0050_00B3);
    load_en_i = 1'b0;
    tick(1);
    chk("basic_hold_release", {31'd0, cpu_hold_o}, 32'd0);
    chk("basic_done_sticky", {31'd0, done_o}, 32'd1);

    // Same frame, wrong checksum.
    start_load();
    chk("badcs_done_cleared", {31'd0, done_o}, 32'd0);
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'hB3, 1); send_byte(8'h00, 1); send_byte(8'h50, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    tick(5);
    chk("badcs_err", {31'd0, err_o}, 32'd1);
    chk("badcs_done", {31'd0, done_o}, 32'd0);
    chk("badcs_writes", 32'(wr_count), 32'd2);
    chk("badcs_hold", {31'd0, cpu_hold_o}, 32'd1);
    end_load();

    // Noise bytes and a short glitch before the sync byte.
    start_load();
    chk("noise_err_cleared", {31'd0, err_o}, 32'd0);
    send_byte(8'h55, 1); send_byte(8'hFF, 1);
    bv_before = bv_count;
    rx_i = 1'b0; tick(4); rx_i = 1'b1; tick(40);
    chk("glitch_no_byte", 32'(bv_count - bv_before), 32'd0);
    send_byte(8'hA5, 1); send_byte(8'h01, 1);
    send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
    send_byte(8'h08, 1);
    tick(5);
    chk("noise_done", {31'd0, done_o}, 32'd1);
    chk("noise_writes", 32'(wr_count), 32'd1);
    chk("noise_w0", mem[0], 32'h1234_5678);
    end_load();

    // Stop bit low on the 4th data byte.
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h01, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 0);
    tick(5);
    chk("ferr_err", {31'd0, err_o}, 32'd1);
    chk("ferr_done", {31'd0, done_o}, 32'd0);
    chk("ferr_writes", 32'(wr_count), 32'd0);
    end_load();

    // Abort after six data bytes.
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
    send_byte(8'h05, 1); send_byte(8'h06, 1);
    chk("abort_hold_before", {31'd0, cpu_hold_o}, 32'd1);
    load_en_i = 1'b0;
    tick(1);
    chk("abort_hold", {31'd0, cpu_hold_o}, 32'd0);
    tick(5);
    chk("abort_writes", 32'(wr_count), 32'd1);
    chk("abort_w0", mem[0], 32'h0403_0201);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_err", {31'd0, err_o}, 32'd0);

    // Zero length.
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h00, 1);
    tick(5);
    chk("n0_err", {31'd0, err_o}, 32'd1);
    chk("n0_writes", 32'(wr_count), 32'd0);
    chk("n0_cnt", 32'(word_cnt_o), 32'd0);
    end_load();

    // Length one past the memory size.
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h81, 1);
    tick(5);
    chk("n129_err", {31'd0, err_o}, 32'd1);
    chk("n129_writes", 32'(wr_count), 32'd0);
    end_load();

    // Full memory: 128 words.
    start_load();
    send_byte(8'hA5, 1); send_byte(8'h80, 1);
    cs = 8'h00;
    for (int i = 0; i < 128; i++) begin
      b0 = 8'(i); b1 = ~8'(i); b2 = 8'h3C; b3 = 8'(i + 1);
      send_byte(b0, 1); send_byte(b1, 1); send_byte(b2, 1); send_byte(b3, 1);
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
    end
    send_byte(cs, 1);
    tick(5);
    chk("n128_done", {31'd0, done_o}, 32'd1);
    chk("n128_err", {31'd0, err_o}, 32'd0);
    chk("n128_cnt", 32'(word_cnt_o), 32'd128);
    chk("n128_writes", 32'(wr_count), 32'd128);
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("n128_w%0d", i), mem[i], {8'(i + 1), 8'h3C, ~8'(i), 8'(i)});
    end
    end_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
